// File: rtl/apb_master.sv
// APB requester: converts valid/ready commands into APB SETUP/ACCESS transfers
// and returns a one-cycle response pulse. A wait-state timeout aborts
// transfers to responders that never assert PREADY.
module apb_master #(
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
    localparam int unsigned CNT_W      = TIMEOUT_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int unsigned CNT_SAT_I  = TIMEOUT_EN ? TIMEOUT_CYCLES : 1;
    localparam int unsigned CNT_LAST_I = TIMEOUT_EN ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CNT_SAT_I);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_LAST_I);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic                  pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  rsp_timeout_q, rsp_timeout_d;

    // Next-state, transfer capture, wait counting and response generation
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        paddr_d       = paddr_q;
        pwrite_d      = pwrite_q;
        pwdata_d      = pwdata_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = '0;
        rsp_err_d     = 1'b0;
        rsp_timeout_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    paddr_d  = cmd_addr;
                    pwrite_d = cmd_write;
                    pwdata_d = cmd_wdata;
                    cnt_d    = '0;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                cnt_d   = '0;
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = PSLVERR;
                    rsp_rdata_d = pwrite_q ? '0 : PRDATA;
                end else begin
                    if (cnt_q != CNT_SAT) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    // Counter is about to reach the limit with PREADY still low
                    if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
                        state_d       = ST_IDLE;
                        rsp_valid_d   = 1'b1;
                        rsp_err_d     = 1'b1;
                        rsp_timeout_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        psel_d    = (state_d != ST_IDLE);
        penable_d = (state_d == ST_ACCESS);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            paddr_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            paddr_q       <= paddr_d;
            pwrite_q      <= pwrite_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign cmd_ready   = (state_q == ST_IDLE);
    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PADDR       = paddr_q;
    assign PWRITE      = pwrite_q;
    assign PWDATA      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: directed cases plus randomized transfers
// checked against a transaction-level model of the APB requester.
module tb_apb_master;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 4;

    logic          PCLK = 1'b0;
    logic          PRESETn;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_err, rsp_timeout;
    logic [DW-1:0] rsp_rdata;
    logic          PSEL, PENABLE, PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA, PRDATA;
    logic          PREADY, PSLVERR;

    int n_checks = 0;
    int n_pass   = 0;

    apb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) u_dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // Transaction-level expectation: responder answers after w wait states
    task automatic model_rsp(input bit wr, input int w, input bit err, input logic [31:0] rd,
                             output int len, output bit e_err, output bit e_to,
                             output logic [31:0] e_rdata);
        if (w < int'(TO)) begin
            len = w + 1; e_err = err; e_to = 1'b0; e_rdata = wr ? 32'd0 : rd;
        end else begin
            len = int'(TO); e_err = 1'b1; e_to = 1'b1; e_rdata = 32'd0;
        end
    endtask

    // Issue one command; responder holds PREADY low for w ACCESS cycles
    task automatic do_xfer(input string tag, input bit wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wd, input int w, input bit err,
                           input logic [DW-1:0] rd);
        int len;
        int e_len;
        bit e_err, e_to;
        logic [31:0] e_rdata;
        check({tag, ".cmd_ready_idle"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
        tick();
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom); cmd_addr = AW'($urandom); cmd_wdata = DW'($urandom);
        check({tag, ".setup_psel"}, {30'd0, PSEL, PENABLE}, 32'd2);
        check({tag, ".setup_ready"}, 32'(cmd_ready), 32'd0);
        check({tag, ".paddr"}, 32'(PADDR), 32'(addr));
        check({tag, ".pwrite"}, 32'(PWRITE), 32'(wr));
        check({tag, ".pwdata"}, PWDATA, wd);
        tick();
        len = 0;
        while (PSEL && PENABLE && len < 20) begin
            if (len == w) begin
                PREADY = 1'b1; PSLVERR = err; PRDATA = rd;
            end else begin
                PREADY = 1'b0; PSLVERR = 1'b1; PRDATA = DW'($urandom);
            end
            len++;
            tick();
        end
        PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = DW'($urandom);
        model_rsp(wr, w, err, rd, e_len, e_err, e_to, e_rdata);
        check({tag, ".access_len"}, 32'(len), 32'(e_len));
        check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, ".rsp_err"}, 32'(rsp_err), 32'(e_err));
        check({tag, ".rsp_timeout"}, 32'(rsp_timeout), 32'(e_to));
        check({tag, ".rsp_rdata"}, rsp_rdata, e_rdata);
        check({tag, ".bus_idle"}, {30'd0, PSEL, PENABLE}, 32'd0);
        check({tag, ".ready_back"}, 32'(cmd_ready), 32'd1);
        check({tag, ".paddr_hold"}, 32'(PADDR), 32'(addr));
        tick();
        check({tag, ".rsp_pulse_end"}, {29'd0, rsp_valid, rsp_err, rsp_timeout}, 32'd0);
        check({tag, ".rdata_clear"}, rsp_rdata, 32'd0);
    endtask

    initial begin
        PRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        tick(); tick();
        PRESETn = 1'b1;
        tick();
        check("rst.bus", {30'd0, PSEL, PENABLE}, 32'd0);
        check("rst.paddr", 32'(PADDR), 32'd0);
        check("rst.pwdata", PWDATA, 32'd0);
        check("rst.pwrite", 32'(PWRITE), 32'd0);
        check("rst.rsp", {29'd0, rsp_valid, rsp_err, rsp_timeout}, 32'd0);
        check("rst.rdata", rsp_rdata, 32'd0);
        check("rst.cmd_ready", 32'(cmd_ready), 32'd1);

        do_xfer("wr0",     1'b1, 16'h0010, 32'hDEADBEEF, 0, 1'b0, 32'h12345678);
        do_xfer("rd1",     1'b0, 16'h0010, 32'h0,        1, 1'b0, 32'hDEADBEEF);
        do_xfer("rderr",   1'b0, 16'h0020, 32'h0,        2, 1'b1, 32'hCAFEF00D);
        do_xfer("tmo",     1'b0, 16'h0030, 32'h0,        50, 1'b0, 32'h0BADBAD0);
        do_xfer("after",   1'b1, 16'h0040, 32'hA5A5A5A5, 0, 1'b0, 32'h0);
        do_xfer("edge3",   1'b0, 16'h0050, 32'h0,        3, 1'b0, 32'h55AA55AA);
        do_xfer("edge4",   1'b1, 16'h0060, 32'h11111111, 4, 1'b0, 32'h0);

        // Reset during ACCESS aborts without a response
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0077; cmd_wdata = 32'h77777777;
        tick();
        cmd_valid = 1'b0;
        tick(); tick();
        check("mid.in_access", {30'd0, PSEL, PENABLE}, 32'd3);
        PRESETn = 1'b0;
        tick();
        check("mid.bus", {30'd0, PSEL, PENABLE}, 32'd0);
        check("mid.rsp", 32'(rsp_valid), 32'd0);
        check("mid.paddr", 32'(PADDR), 32'd0);
        PRESETn = 1'b1;
        tick();
        check("mid.no_rsp", 32'(rsp_valid), 32'd0);
        check("mid.ready", 32'(cmd_ready), 32'd1);

        for (int i = 0; i < 40; i++) begin
            do_xfer("rnd", 1'($urandom), AW'($urandom), DW'($urandom),
                    int'($urandom_range(0, 6)), 1'($urandom), DW'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB requester (initiator) that turns single-word commands from an internal valid/ready command port into APB SETUP→ACCESS transfers.
- Samples the responder's PREADY, PRDATA and PSLVERR, and returns a one-cycle response pulse.
- Sits between a bus-control/CSR front end and APB responders such as the team's register-file slave.
- Adds a wait-state timeout so a hung responder cannot stall the requester.

Parameters:
- ADDR_WIDTH, 16: PADDR / cmd_addr width.
- DATA_WIDTH, 32: PWDATA / PRDATA / cmd_wdata / rsp_rdata width.
- TIMEOUT_CYCLES, 16: number of ACCESS cycles with PREADY=0 before abort; 0 disables the timeout.

Ports:
- PCLK  in  1  clock, all logic on rising edge.
- PRESETn  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_WIDTH  transfer address.
- cmd_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes and timeouts).
- rsp_err  out  1  PSLVERR seen, or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PADDR  out  ADDR_WIDTH  APB address.
- PWRITE  out  1  APB direction.
- PWDATA  out  DATA_WIDTH  APB write data.
- PRDATA  in  DATA_WIDTH  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB error.

Behaviour:
- Reset is synchronous, sampled on the PCLK rising edge with PRESETn=0. Reset values:
  - state=IDLE.
  - PSEL=0, PENABLE=0, PADDR=0, PWRITE=0, PWDATA=0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0.
  - wait counter=0.
- All outputs are registered. cmd_ready is decoded directly from the state register: 1 only in IDLE.
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE: on cmd_valid & cmd_ready, register PADDR/PWRITE/PWDATA from the cmd_* inputs, then go to SETUP.
  - SETUP: PSEL=1, PENABLE=0; always go to ACCESS after exactly one cycle.
  - ACCESS: PSEL=1, PENABLE=1.
    - If PREADY=1: go to IDLE, and in the next cycle pulse rsp_valid with:
      - rsp_err = PSLVERR.
      - rsp_rdata = PRDATA for reads, 0 for writes.
      - rsp_timeout = 0.
    - If PREADY=0: increment the wait counter.
- Latency with a zero-wait responder:
  - Accept in cycle N, SETUP in N+1, ACCESS in N+2, rsp_valid and cmd_ready=1 in N+3.
  - Each wait state adds 1 cycle.
  - The fastest issue rate is one transfer per 3 cycles; no back-to-back ACCESS→SETUP.
- PSLVERR and PRDATA are ignored unless PREADY=1 in ACCESS.
- Timeout (TIMEOUT_CYCLES>0):
  - The counter clears on SETUP entry.
  - When the counter reaches TIMEOUT_CYCLES while PREADY is still 0: next cycle PSEL=0, PENABLE=0, state=IDLE, and rsp_valid=1 with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - If PREADY=1 in the same cycle the counter reaches the limit, normal completion wins.
- rsp_valid is a single-cycle pulse with no back-pressure. rsp_rdata, rsp_err and rsp_timeout are valid only while rsp_valid=1 and clear to 0 otherwise.
- PADDR, PWRITE and PWDATA hold their last values in IDLE (no toggling); they update only on command accept.
- cmd_* inputs are ignored outside IDLE; a cmd_valid held during a transfer is accepted when the FSM returns to IDLE.
- Reset mid-transfer: at the reset edge all outputs return to reset values and no response is issued for the aborted transfer.
- The wait counter saturates. Its width is clog2(TIMEOUT_CYCLES+1), minimum 1.

Test Plan:
- Reset held 2 cycles, then released → all outputs 0, cmd_ready=1 in the first post-reset cycle.
- Write addr 0x0010, data 0xDEADBEEF; responder PREADY=1 on the first ACCESS cycle → SETUP in N+1, ACCESS in N+2, rsp_valid=1 in N+3 with rsp_err=0 and rsp_rdata=0; PSEL/PENABLE low in N+3.
- Read addr 0x0010; responder asserts PREADY one cycle after ACCESS entry with PRDATA=0xDEADBEEF → ACCESS lasts 2 cycles, rsp_rdata=0xDEADBEEF, rsp_err=0.
- Read with PREADY=1 and PSLVERR=1 → rsp_valid=1, rsp_err=1, rsp_timeout=0; a PSLVERR=1 pulse during a PREADY=0 wait cycle has no effect.
- TIMEOUT_CYCLES=4, responder never asserts PREADY → exactly 4 wait cycles in ACCESS, then PSEL=0 and rsp_valid=1 with rsp_err=1, rsp_timeout=1, rsp_rdata=0; the next command completes normally.
- PRESETn driven low during ACCESS → next edge PSEL=0 and PENABLE=0, no rsp_valid pulse; after release, cmd_ready=1.
